// File: rtl/uart_tx_ctrl.sv
// UART frame sequencer: pops bytes from the TX FIFO and serialises them as 8N1/8N2 frames, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bits.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LATCH  = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd6;
`endif

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [CNT_W-1:0]     baud_cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 baud_end;
    logic                 start_ok;
    logic                 tx_nxt;
    logic                 done_nxt;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
    logic                 parity_nxt;
`endif

    assign baud_end = (baud_cnt == CNT_LAST);
    // Only consulted in IDLE and on the last STOP clock, so mid-frame changes are ignored.
    assign start_ok = tx_en && !fifo_empty;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = baud_end ? '0 : baud_cnt + CNT_W'(1);
        idx_nxt   = bit_idx;
        shift_nxt = shift_reg;
`ifdef UART_TX_PARITY_EN
        parity_nxt = parity_bit;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (start_ok) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                cnt_nxt   = '0;
                state_nxt = LATCH;
            end
            LATCH: begin
                cnt_nxt   = '0;
                idx_nxt   = '0;
                shift_nxt = fifo_data;
`ifdef UART_TX_PARITY_EN
                parity_nxt = ^fifo_data;
`endif
                state_nxt = START;
            end
            START: begin
                if (baud_end) begin
                    idx_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shift_nxt = shift_reg >> 1;
                    if (bit_idx == DATA_LAST) begin
                        idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = bit_idx + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    idx_nxt   = '0;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    if (bit_idx == STOP_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = start_ok ? FETCH : IDLE;
                    end else begin
                        idx_nxt = bit_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                cnt_nxt   = '0;
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            START:  tx_nxt = 1'b0;
            DATA:   tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_nxt = parity_nxt;
`endif
            default: tx_nxt = 1'b1;
        endcase
    end

    assign done_nxt = (state_nxt == STOP) && (cnt_nxt == CNT_LAST) && (idx_nxt == STOP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= cnt_nxt;
            bit_idx    <= idx_nxt;
            shift_reg  <= shift_nxt;
            tx         <= tx_nxt;
            fifo_rd_en <= (state_nxt == FETCH);
            tx_busy    <= (state_nxt != IDLE);
            tx_done    <= done_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_bit <= 1'b0;
        end else begin
            parity_bit <= parity_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: FIFO model plus a per-clock frame reference built from the UART framing rules.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
    localparam int DB  = 8;
    localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 1 + DB + 1 + SB;
`else
    localparam int NBITS = 1 + DB + SB;
`endif

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          tx_en      = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DB-1:0] fifo_data  = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          tx_busy;
    logic          tx_done;

    int            n_checks    = 0;
    int            n_fail      = 0;
    int            n_pops      = 0;
    int            n_underflow = 0;
    int            exp_pops    = 0;
    logic [DB-1:0] fifo_q[$];

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .STOP_BITS   (SB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    // FIFO with registered read data and a registered empty flag.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() == 0) begin
                n_underflow++;
            end else begin
                fifo_data <= fifo_q[0];
                fifo_q.delete(0);
                n_pops++;
            end
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial bit i of the frame carrying b: start, LSB-first data, optional parity, stop.
    function automatic logic frame_bit(input logic [DB-1:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= DB) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == DB + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic push(input logic [DB-1:0] b);
        fifo_q.push_back(b);
        exp_pops++;
    endtask

    // Expects a pop within max_wait clocks, then walks the whole frame clock by clock.
    // drop_bit >= 0 releases tx_en during that data bit; rst_bit >= 0 resets during that data bit.
    task automatic check_frame(input logic [DB-1:0] b, input int max_wait,
                               input int drop_bit, input int rst_bit);
        int w = 0;
        while (fifo_rd_en !== 1'b1 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        chk("rd_en_pulse", fifo_rd_en, 1);
        if (fifo_rd_en !== 1'b1) return;
        chk("fetch_busy", tx_busy, 1);
        chk("fetch_tx", tx, 1);
        @(negedge clk);
        chk("latch_rd_en", fifo_rd_en, 0);
        chk("latch_tx", tx, 1);
        chk("latch_busy", tx_busy, 1);
        for (int k = 0; k < NBITS * CPB; k++) begin
            @(negedge clk);
            chk($sformatf("tx_bit%0d_byte%0h", k / CPB, b), tx, frame_bit(b, k / CPB));
            chk("tx_done", tx_done, (k == NBITS * CPB - 1));
            chk("frame_busy", tx_busy, 1);
            chk("rd_en_quiet", fifo_rd_en, 0);
            if (drop_bit >= 0 && k == (1 + drop_bit) * CPB + 1) tx_en = 1'b0;
            if (rst_bit >= 0 && k == (1 + rst_bit) * CPB + 1) begin
                #1 rst = 1'b1;
                #1;
                chk("async_rst_tx", tx, 1);
                chk("async_rst_busy", tx_busy, 0);
                chk("async_rst_rd_en", fifo_rd_en, 0);
                chk("async_rst_done", tx_done, 0);
                return;
            end
        end
    endtask

    initial begin
        logic [DB-1:0] bytes[3];
        int n;

        #2 rst = 1'b1;
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_rd_en", fifo_rd_en, 0);
        chk("reset_done", tx_done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5.
        tx_en = 1'b1;
        push(8'hA5);
        check_frame(8'hA5, 6, -1, -1);
        @(negedge clk);
        chk("a5_idle_busy", tx_busy, 0);
        chk("a5_idle_tx", tx, 1);
        repeat (10) @(negedge clk);
        chk("a5_pops", n_pops, exp_pops);

        // Back-to-back 0x00, 0xFF: second pop on the clock right after tx_done.
        push(8'h00);
        push(8'hFF);
        check_frame(8'h00, 6, -1, -1);
        check_frame(8'hFF, 1, -1, -1);
        @(negedge clk);
        chk("b2b_idle_busy", tx_busy, 0);
        chk("b2b_pops", n_pops, exp_pops);

        // Parity-relevant byte 0x07.
        push(8'h07);
        check_frame(8'h07, 6, -1, -1);
        @(negedge clk);
        chk("b07_idle_busy", tx_busy, 0);

        // Random bursts of 1..3 bytes.
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                bytes[j] = DB'($urandom);
                push(bytes[j]);
            end
            for (int j = 0; j < n; j++) begin
                check_frame(bytes[j], (j == 0) ? 6 : 1, -1, -1);
            end
            @(negedge clk);
            chk("rand_idle_busy", tx_busy, 0);
            chk("rand_pops", n_pops, exp_pops);
        end

        // tx_en drops during bit 3 of 0x3C with a second byte waiting.
        push(8'h3C);
        push(8'h55);
        check_frame(8'h3C, 6, 3, -1);
        repeat (20) @(negedge clk);
        chk("txen_drop_pops", n_pops, exp_pops - 1);
        chk("txen_drop_tx", tx, 1);
        chk("txen_drop_busy", tx_busy, 0);
        tx_en = 1'b1;
        check_frame(8'h55, 6, -1, -1);
        @(negedge clk);
        chk("txen_resume_pops", n_pops, exp_pops);

        // Reset during bit 5 of 0x81; FIFO is empty afterwards.
        push(8'h81);
        check_frame(8'h81, 6, -1, 5);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_tx", tx, 1);
        chk("post_rst_busy", tx_busy, 0);
        chk("post_rst_pops", n_pops, exp_pops);

        chk("no_underflow", n_underflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
